// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared state, grant encodings and defaults for the Ethernet TX arbiter
package eth_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_e;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_ARP = 2'd1;
  localparam logic [1:0] GNT_ICMP = 2'd2;
  localparam logic [1:0] GNT_UDP = 2'd3;
  localparam int IFG_DEFAULT = 12;
  localparam int MAX_CONSEC_DEFAULT = 4;
endpackage

// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: byte-wide valid/ready stream with end-of-frame marker
interface eth_tx_arbiter_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_tx_arb_sel.sv
// eth_tx_arb_sel: fixed-priority ARP > ICMP > UDP picker with UDP starvation override
module eth_tx_arb_sel
  import eth_tx_arb_pkg::*;
(
  input  logic       arp_valid_i,
  input  logic       icmp_valid_i,
  input  logic       udp_valid_i,
  input  logic [3:0] consec_i,
  input  logic [3:0] max_consec_i,
  output logic [1:0] grant_o,
  output logic       consec_inc_o
);
  logic starve;
  assign starve = udp_valid_i && consec_i == max_consec_i;
  assign grant_o = starve ? GNT_UDP : arp_valid_i ? GNT_ARP : icmp_valid_i ? GNT_ICMP : udp_valid_i ? GNT_UDP : GNT_NONE;
  assign consec_inc_o = udp_valid_i && !starve && (arp_valid_i || icmp_valid_i);
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-atomic three-source TX byte stream arbiter with inter-frame gap
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int IFG_CYCLES = IFG_DEFAULT,
  parameter int MAX_CONSEC = MAX_CONSEC_DEFAULT
) (
  input  logic             gmii_tx_clk,
  input  logic             gmii_rst,
  eth_tx_arbiter_if.slave  s_arp,
  eth_tx_arbiter_if.slave  s_icmp,
  eth_tx_arbiter_if.slave  s_udp,
  eth_tx_arbiter_if.master m,
  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic             frame_done_o
);
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [GW-1:0] IFG = GW'(IFG_CYCLES);
  localparam logic [3:0] MAXC = 4'(MAX_CONSEC);
  state_e state_q, state_d;
  logic [1:0] grant_q, grant_d, nxt_grant;
  logic [3:0] consec_q, consec_d;
  logic [GW-1:0] gap_q, gap_d;
  logic done_q, consec_inc, fire;
  eth_tx_arb_sel u_sel (
    .arp_valid_i  (s_arp.tvalid),
    .icmp_valid_i (s_icmp.tvalid),
    .udp_valid_i  (s_udp.tvalid),
    .consec_i     (consec_q),
    .max_consec_i (MAXC),
    .grant_o      (nxt_grant),
    .consec_inc_o (consec_inc)
  );
  // grant_q is GNT_NONE outside XFER, so the mux alone gates the stream
  assign m.tdata = grant_q == GNT_ARP ? s_arp.tdata : grant_q == GNT_ICMP ? s_icmp.tdata : s_udp.tdata;
  assign m.tlast = grant_q == GNT_ARP ? s_arp.tlast : grant_q == GNT_ICMP ? s_icmp.tlast : s_udp.tlast;
  assign m.tvalid = grant_q == GNT_ARP ? s_arp.tvalid : grant_q == GNT_ICMP ? s_icmp.tvalid : grant_q == GNT_UDP && s_udp.tvalid;
  assign s_arp.tready = grant_q == GNT_ARP && m.tready;
  assign s_icmp.tready = grant_q == GNT_ICMP && m.tready;
  assign s_udp.tready = grant_q == GNT_UDP && m.tready;
  assign fire = m.tvalid && m.tready && m.tlast;
  assign grant_o = grant_q;
  assign busy_o = state_q != IDLE;
  assign frame_done_o = done_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    consec_d = consec_q;
    gap_d = gap_q;
    if (state_q == IDLE) begin
      consec_d = consec_inc ? (consec_q == MAXC ? consec_q : consec_q + 4'd1) : 4'd0;
      if (nxt_grant != GNT_NONE) begin
        grant_d = nxt_grant;
        state_d = XFER;
      end
    end else if (state_q == XFER) begin
      if (fire) begin
        grant_d = GNT_NONE;
        gap_d = IFG;
        state_d = IFG_CYCLES == 0 ? IDLE : GAP;
      end
    end else begin
      gap_d = gap_q - GW'(1);
      state_d = gap_q == GW'(1) ? IDLE : GAP;
    end
  end
  always_ff @(posedge gmii_tx_clk) begin
    if (gmii_rst) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      consec_q <= 4'd0;
      gap_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      consec_q <= consec_d;
      gap_q <= gap_d;
      done_q <= fire;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench with directed frame vectors for eth_tx_arbiter
module tb_eth_tx_arbiter;
  import eth_tx_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  eth_tx_arbiter_if a_arp();
  eth_tx_arbiter_if a_icmp();
  eth_tx_arbiter_if a_udp();
  eth_tx_arbiter_if a_m();
  eth_tx_arbiter_if b_arp();
  eth_tx_arbiter_if b_icmp();
  eth_tx_arbiter_if b_udp();
  eth_tx_arbiter_if b_m();
  logic [1:0] a_grant, b_grant;
  logic a_busy, b_busy, a_done, b_done;
  eth_tx_arbiter #(.IFG_CYCLES(12), .MAX_CONSEC(4)) dut_a (
    .gmii_tx_clk(clk), .gmii_rst(rst), .s_arp(a_arp), .s_icmp(a_icmp), .s_udp(a_udp), .m(a_m),
    .grant_o(a_grant), .busy_o(a_busy), .frame_done_o(a_done)
  );
  eth_tx_arbiter #(.IFG_CYCLES(0), .MAX_CONSEC(4)) dut_b (
    .gmii_tx_clk(clk), .gmii_rst(rst), .s_arp(b_arp), .s_icmp(b_icmp), .s_udp(b_udp), .m(b_m),
    .grant_o(b_grant), .busy_o(b_busy), .frame_done_o(b_done)
  );
  logic [8:0] arp_q[$], icmp_q[$], udp_q[$];
  logic [10:0] sb[$];
  int first_cyc[$], last_cyc[$];
  int checks = 0, errors = 0, cyc = 0, beats = 0;
  logic first = 1'b1, arp_pause = 1'b0, rand_rdy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic src_push(input logic [1:0] g, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      logic [8:0] e;
      e = {i == len - 1, base + 8'(i)};
      if (g == GNT_ARP) arp_q.push_back(e);
      else if (g == GNT_ICMP) icmp_q.push_back(e);
      else udp_q.push_back(e);
    end
  endtask

  task automatic sb_push(input logic [1:0] g, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) sb.push_back({g, i == len - 1, base + 8'(i)});
  endtask

  function automatic logic src_valid(input logic [1:0] g);
    return g == GNT_ARP ? a_arp.tvalid : g == GNT_ICMP ? a_icmp.tvalid : a_udp.tvalid;
  endfunction

  task automatic wait_latency(input string name, input logic [1:0] g);
    int n = 0;
    while (!src_valid(g) && n < 10) begin
      tick();
      n++;
    end
    chk({name, "_req"}, src_valid(g), 1);
    chk({name, "_grant_before"}, a_grant, GNT_NONE);
    tick();
    chk({name, "_grant_after"}, a_grant, g);
    chk({name, "_first_beat_valid"}, a_m.tvalid, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || a_busy) && n < 1000) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin : drv
    logic f_a, f_i, f_u;
    forever begin
      @(negedge clk);
      #1;
      a_arp.tvalid = arp_q.size() > 0 && !arp_pause;
      a_arp.tlast = arp_q.size() > 0 ? arp_q[0][8] : 1'b0;
      a_arp.tdata = arp_q.size() > 0 ? arp_q[0][7:0] : 8'h0;
      a_icmp.tvalid = icmp_q.size() > 0;
      a_icmp.tlast = icmp_q.size() > 0 ? icmp_q[0][8] : 1'b0;
      a_icmp.tdata = icmp_q.size() > 0 ? icmp_q[0][7:0] : 8'h0;
      a_udp.tvalid = udp_q.size() > 0;
      a_udp.tlast = udp_q.size() > 0 ? udp_q[0][8] : 1'b0;
      a_udp.tdata = udp_q.size() > 0 ? udp_q[0][7:0] : 8'h0;
      a_m.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      f_a = a_arp.tvalid && a_arp.tready;
      f_i = a_icmp.tvalid && a_icmp.tready;
      f_u = a_udp.tvalid && a_udp.tready;
      @(posedge clk);
      if (f_a) void'(arp_q.pop_front());
      if (f_i) void'(icmp_q.pop_front());
      if (f_u) void'(udp_q.pop_front());
    end
  end

  initial begin : mon
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (a_m.tvalid && a_m.tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %0h expected none", {a_grant, a_m.tlast, a_m.tdata});
        end else begin
          exp = sb.pop_front();
          chk("beat", {a_grant, a_m.tlast, a_m.tdata}, exp);
        end
        if (first) first_cyc.push_back(cyc);
        if (a_m.tlast) last_cyc.push_back(cyc);
        first = a_m.tlast;
        beats++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, pulses;
    b_arp.tvalid = 0; b_arp.tdata = 0; b_arp.tlast = 0;
    b_udp.tvalid = 0; b_udp.tdata = 0; b_udp.tlast = 0;
    b_icmp.tvalid = 0; b_icmp.tdata = 8'hc3; b_icmp.tlast = 1;
    b_m.tready = 1;
    repeat (3) tick();
    chk("rst_grant", a_grant, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_mvalid", a_m.tvalid, 0);
    chk("rst_treadys", {a_arp.tready, a_icmp.tready, a_udp.tready}, 0);
    rst = 0;
    tick();
    chk("idle_busy", a_busy, 0);
    // single 64-byte UDP frame
    first_cyc.delete(); last_cyc.delete();
    src_push(GNT_UDP, 64, 8'h00);
    sb_push(GNT_UDP, 64, 8'h00);
    wait_latency("t1", GNT_UDP);
    n = 0;
    while (!a_done && n < 200) begin
      tick();
      n++;
    end
    chk("t1_done_seen", a_done, 1);
    chk("t1_contiguous", last_cyc.size() > 0 && first_cyc.size() > 0 ? last_cyc[0] - first_cyc[0] : -1, 63);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      pulses += int'(a_done);
      chk("t1_busy_gap", a_busy, 1);
      tick();
    end
    chk("t1_busy_fall", a_busy, 0);
    chk("t1_done_pulses", pulses, 1);
    chk("t1_drained", sb.size(), 0);
    // simultaneous ARP, ICMP, UDP
    first_cyc.delete(); last_cyc.delete();
    src_push(GNT_ARP, 4, 8'h10); src_push(GNT_ICMP, 3, 8'h20); src_push(GNT_UDP, 5, 8'h30);
    sb_push(GNT_ARP, 4, 8'h10); sb_push(GNT_ICMP, 3, 8'h20); sb_push(GNT_UDP, 5, 8'h30);
    wait_idle("t2");
    chk("t2_frames", first_cyc.size(), 3);
    chk("t2_space_arp_icmp", first_cyc.size() > 2 ? first_cyc[1] - last_cyc[0] : -1, 14);
    chk("t2_space_icmp_udp", first_cyc.size() > 2 ? first_cyc[2] - last_cyc[1] : -1, 14);
    // starvation guard: I I I I U I I I I U I
    for (int k = 0; k < 9; k++) src_push(GNT_ICMP, 2, 8'(16 * k));
    src_push(GNT_UDP, 3, 8'hd0); src_push(GNT_UDP, 3, 8'he0);
    for (int k = 0; k < 4; k++) sb_push(GNT_ICMP, 2, 8'(16 * k));
    sb_push(GNT_UDP, 3, 8'hd0);
    for (int k = 4; k < 8; k++) sb_push(GNT_ICMP, 2, 8'(16 * k));
    sb_push(GNT_UDP, 3, 8'he0);
    sb_push(GNT_ICMP, 2, 8'h80);
    wait_idle("t3");
    // backpressure and mid-frame stall on ARP while ICMP waits
    first_cyc.delete(); last_cyc.delete();
    rand_rdy = 1;
    src_push(GNT_ARP, 20, 8'h50); src_push(GNT_ICMP, 2, 8'h70);
    sb_push(GNT_ARP, 20, 8'h50); sb_push(GNT_ICMP, 2, 8'h70);
    b0 = beats;
    n = 0;
    while (beats < b0 + 8 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_mid_reached", beats - b0, 8);
    arp_pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_mvalid", a_m.tvalid, 0);
      chk("t4_stall_grant", a_grant, GNT_ARP);
      chk("t4_stall_icmp_rdy", a_icmp.tready, 0);
    end
    arp_pause = 0;
    wait_idle("t4");
    rand_rdy = 0;
    chk("t4_icmp_after_gap", first_cyc.size() > 1 ? int'(first_cyc[1] - last_cyc[0] >= 14) : 0, 1);
    // reset mid-frame
    src_push(GNT_UDP, 20, 8'h80);
    sb_push(GNT_UDP, 20, 8'h80);
    b0 = beats;
    n = 0;
    while (beats < b0 + 10 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_byte10", beats - b0, 10);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    udp_q.delete();
    sb.delete();
    first = 1;
    #4;
    chk("t5_mvalid", a_m.tvalid, 0);
    chk("t5_grant", a_grant, 0);
    chk("t5_busy", a_busy, 0);
    src_push(GNT_ARP, 3, 8'h90);
    sb_push(GNT_ARP, 3, 8'h90);
    wait_latency("t5", GNT_ARP);
    wait_idle("t5");
    // zero gap, back-to-back single-byte ICMP frames
    b_icmp.tvalid = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t6_mvalid", b_m.tvalid, k % 2);
      chk("t6_grant", b_grant, k % 2 == 1 ? GNT_ICMP : GNT_NONE);
      chk("t6_done", b_done, int'(k % 2 == 0));
      chk("t6_data", b_m.tvalid ? int'(b_m.tdata) : 8'hc3, 8'hc3);
    end
    b_icmp.tvalid = 0;
    tick();
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
